instr_obi_mem: RTL and testbench
================================

# instr_obi_mem

Instruction-side OBI memory responder feeding the fetch stage: accepts `instr_req`/`instr_addr` from the prefetch logic and returns `instr_gnt`, `instr_rvalid` and `instr_rdata` with configurable, in-order response latency. It sits directly upstream of the fetch stage in the prefetch bench and in simulation top-levels. It holds a word-addressed instruction array, preloaded through a dedicated write port.

## Interface
- `DEPTH_WORDS`, 1024: instruction array size in 32-bit words (power of two).
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0.
- `RVALID_LATENCY`, 1: cycles from grant cycle to `instr_rvalid_o` (1..8).
- `MAX_OUTSTANDING`, 2: max granted-but-unanswered requests (1..8).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_req_i`  in  1  fetch request.
- `instr_addr_i`  in  32  byte address; bits [1:0] ignored.
- `instr_gnt_o`  out  1  request accepted this cycle (combinational).
- `instr_rvalid_o`  out  1  response data valid (registered).
- `instr_rdata_o`  out  32  instruction word (registered).
- `load_we_i`  in  1  preload write strobe.
- `load_addr_i`  in  32  preload byte address; bits [1:0] ignored.
- `load_wdata_i`  in  32  preload data.

## Operation
- Word index = (addr − BASE_ADDR) >> 2; out of range if index ≥ DEPTH_WORDS.
- Grant: `instr_gnt_o = instr_req_i && (outstanding < MAX_OUTSTANDING)` (further gated by stall, see Configuration).
- On grant: array read at captured index; data (or 32'h0000_0000 if out of range, decodes illegal) enters response delay line.
- Responses strictly in grant order; one `rvalid` per grant, never merged or dropped.
- Outstanding counter: +1 on grant, −1 on rvalid, unchanged when both same cycle; never exceeds MAX_OUTSTANDING, never underflows.
- Preload write: `load_we_i` writes array at index if in range; out-of-range writes ignored.
- Write and grant to same index same cycle: grant returns old data.
- Address may change while `instr_req_i` high and not granted; only granted-cycle address matters.
- Array contents not cleared by reset.

## Timing
- Reset values: `instr_rvalid_o`=0, `instr_rdata_o`=0, outstanding=0, delay line empty.
- Grant in cycle T → `instr_rvalid_o` high in cycle T+RVALID_LATENCY, one cycle wide.
- Back-to-back grants every cycle sustained when MAX_OUTSTANDING ≥ RVALID_LATENCY+1; otherwise throughput limited by counter.
- `instr_rdata_o` holds last response value when `instr_rvalid_o` low.
- Reset mid-operation: all in-flight responses discarded immediately; no `rvalid` emitted after reset for pre-reset grants.
- `instr_gnt_o` is 0 while `rst` high.

## Configuration
- `INSTR_MEM_GNT_STALL_EN`: defined → 8-bit Fibonacci LFSR (taps 8,6,5,4; reset 8'hA5; advances every cycle) additionally blocks grant when `lfsr[1:0]==2'b00`, exercising fetch stall paths. Not defined → grant depends only on request and outstanding count; no LFSR logic present.

## Structure
- Package `instr_mem_pkg`: latency/outstanding limits, `INSTR_ILLEGAL` (32'h0000_0000), LFSR seed/taps, response entry struct (valid + 32-bit data).
- Sub-module `instr_mem_resp_pipe`: fixed-depth delay line of response entries, async reset, flush on reset.

## Test plan
- Preload words 0..3 with 32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193; request 0x0,0x4,0x8,0xC back-to-back (LATENCY=1, OUTSTANDING=2) → gnt every cycle, rvalid cycles T+1..T+4 with those words in order.
- LATENCY=3, OUTSTANDING=2, continuous request → gnt pattern 1,1,0,0,1,1…; outstanding never exceeds 2; rvalid count equals gnt count.
- Request addr 0x0000_1000 with DEPTH_WORDS=1024 → granted, rdata 32'h0000_0000 one cycle later.
- Same-cycle preload write 32'hDEAD_BEEF and granted fetch to 0x10 (old 32'h0000_0013) → returns 32'h0000_0013; next fetch to 0x10 returns 32'hDEAD_BEEF.
- Assert `rst` with two responses in flight (LATENCY=3) → rvalid stays 0 through and after reset, rdata=0, outstanding=0; first post-reset fetch answered normally.
- With `INSTR_MEM_GNT_STALL_EN`, request held 64 cycles → gnt low on exactly the cycles where LFSR[1:0]==0 per reference model; all granted fetches answered in order.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-side OBI memory responder.
// The LFSR helpers are only used when INSTR_MEM_GNT_STALL_EN is defined.
package instr_mem_pkg;

    localparam int unsigned MAX_RVALID_LATENCY    = 8;
    localparam int unsigned MAX_OUTSTANDING_LIMIT = 8;

    localparam logic [31:0] INSTR_ILLEGAL = 32'h0000_0000;

    // Fibonacci taps 8,6,5,4 map to state bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } resp_entry_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/instr_mem_resp_pipe.sv
// Fixed-depth response delay line; the last stage keeps its data while idle
// so the registered read data holds the most recent response.
module instr_mem_resp_pipe
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  resp_entry_t in_i,
    output resp_entry_t out_o
);

    resp_entry_t [DEPTH-1:0] stage_q;
    resp_entry_t [DEPTH-1:0] stage_d;

    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
        stage_d[0] = in_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (!stage_d[DEPTH-1].valid) begin
            stage_d[DEPTH-1].data = stage_q[DEPTH-1].data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples its pre-edge neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/instr_obi_mem.sv
// Instruction-side OBI memory responder with in-order, fixed-latency responses.
// Optional INSTR_MEM_GNT_STALL_EN adds pseudo-random grant stalls from an LFSR.
module instr_obi_mem
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RVALID_LATENCY  = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] BYTE_SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]      fetch_off, load_off;
    logic             fetch_in_range, load_in_range;
    logic [IDX_W-1:0] fetch_idx, load_idx;
    logic [31:0]      rd_word;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;
    resp_entry_t      pipe_in, pipe_out;

    // Offsets below BASE_ADDR wrap to large values and fall out of range.
    assign fetch_off      = instr_addr_i - BASE_ADDR;
    assign load_off       = load_addr_i - BASE_ADDR;
    assign fetch_in_range = {1'b0, fetch_off} < BYTE_SPAN;
    assign load_in_range  = {1'b0, load_off} < BYTE_SPAN;
    assign fetch_idx      = fetch_off[IDX_W+1:2];
    assign load_idx       = load_off[IDX_W+1:2];

    // NOTE: the array has no reset; preloaded contents survive rst and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (load_we_i && load_in_range) begin
            mem_q[load_idx] <= load_wdata_i;
        end
    end

    // Asynchronous read sees the pre-write word when a load hits the same index.
    assign rd_word = fetch_in_range ? mem_q[fetch_idx] : INSTR_ILLEGAL;

`ifdef INSTR_MEM_GNT_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign instr_gnt_o = instr_req_i && !rst && !stall
                         && (cnt_q < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        cnt_d = cnt_q;
        if (instr_gnt_o && !pipe_out.valid) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!instr_gnt_o && pipe_out.valid) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pipe_in = '{valid: instr_gnt_o, data: rd_word};

    instr_mem_resp_pipe #(
        .DEPTH (RVALID_LATENCY)
    ) u_resp_pipe (
        .clk   (clk),
        .rst   (rst),
        .in_i  (pipe_in),
        .out_o (pipe_out)
    );

    assign instr_rvalid_o = pipe_out.valid;
    assign instr_rdata_o  = pipe_out.data;

endmodule

// File: tb/tb_instr_obi_mem.sv
// Self-checking bench: two responders (latency 1 and 3, two outstanding) driven
// from a vector table and hand sequences, with an in-order response scoreboard.
`timescale 1ns/1ps
module tb_instr_obi_mem;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int OUT_N = 2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;
    typedef sb_t sbq_t[$];

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] laddr;
        logic [31:0] wdata;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [31:0] addr_a = '0, addr_b = '0;
    logic        we = 1'b0;
    logic [31:0] laddr = '0, wdata = '0;
    logic        gnt_a, gnt_b, rv_a, rv_b;
    logic [31:0] rd_a, rd_b;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ng_a = 0, nr_a = 0, ng_b = 0, nr_b = 0;
    sbq_t        sb_a, sb_b;
    logic [31:0] last_a = '0, last_b = '0;
    logic [31:0] model [1024];
    logic [7:0]  lfsr_m;

    always #5 clk = ~clk;

    instr_obi_mem #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RVALID_LATENCY(LAT_A), .MAX_OUTSTANDING(OUT_N)
    ) dut_a (
        .clk(clk), .rst(rst), .instr_req_i(req_a), .instr_addr_i(addr_a),
        .instr_gnt_o(gnt_a), .instr_rvalid_o(rv_a), .instr_rdata_o(rd_a),
        .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata)
    );

    instr_obi_mem #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RVALID_LATENCY(LAT_B), .MAX_OUTSTANDING(OUT_N)
    ) dut_b (
        .clk(clk), .rst(rst), .instr_req_i(req_b), .instr_addr_i(addr_b),
        .instr_gnt_o(gnt_b), .instr_rvalid_o(rv_b), .instr_rdata_o(rd_b),
        .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata)
    );

    // Reference memory: out-of-range (>= 4 KiB) writes are dropped.
    initial for (int i = 0; i < 1024; i++) model[i] = '0;
    always @(posedge clk) if (we && laddr < 32'h1000) model[laddr[11:2]] <= wdata;

    // Reference stall LFSR (x^8+x^6+x^5+x^4), seeded at reset.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input string tag, input int lat, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic [31:0] gaddr,
                       inout sbq_t q, inout logic [31:0] last, inout int ng, inout int nr);
        sb_t e;
        if (rst) begin
            q.delete();
            last = '0;
            return;
        end
        if (rv) begin
            nr++;
            if (q.size() == 0) begin
                check({tag, "_spurious_rvalid"}, 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check({tag, "_rdata"}, rd, e.data);
                check({tag, "_rvalid_cycle"}, 32'(cyc), 32'(e.due));
            end
            last = rd;
        end else begin
            check({tag, "_rdata_hold"}, rd, last);
            if (q.size() != 0 && q[0].due <= cyc) begin
                check({tag, "_rvalid_missing"}, 32'd0, 32'd1);
                void'(q.pop_front());
            end
        end
        if (gnt) begin
            ng++;
            e.data = (gaddr < 32'h1000) ? model[gaddr[11:2]] : 32'h0;
            e.due  = cyc + lat;
            q.push_back(e);
            check({tag, "_outstanding_limit"}, 32'(q.size() > OUT_N), 32'd0);
        end
    endtask

    // Inputs are driven 1 ns after the edge; outputs are sampled 3 ns later.
    task automatic settle();
        #3;
    endtask

    task automatic cycle_end();
        mon("a", LAT_A, gnt_a, rv_a, rd_a, addr_a, sb_a, last_a, ng_a, nr_a);
        mon("b", LAT_B, gnt_b, rv_b, rd_b, addr_b, sb_b, last_b, ng_b, nr_b);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic vec_t v(input logic req, input logic [31:0] addr, input logic w,
                               input logic [31:0] la, input logic [31:0] wd,
                               input logic g, input logic rv, input logic [31:0] rd);
        vec_t r;
        r = '{req, addr, w, la, wd, g, rv, rd};
        return r;
    endfunction

    logic [31:0] pre [5];
    vec_t        vecs [16];
    logic        got;

    initial begin
        pre = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0000_0013};
        vecs[0]  = v(1, 32'h0000_0000, 0, 0, 0,                           1, 0, 32'h0);
        vecs[1]  = v(1, 32'h0000_0004, 0, 0, 0,                           1, 1, 32'h0000_0013);
        vecs[2]  = v(1, 32'h0000_0008, 0, 0, 0,                           1, 1, 32'h0010_0093);
        vecs[3]  = v(1, 32'h0000_000C, 0, 0, 0,                           1, 1, 32'h0020_0113);
        vecs[4]  = v(0, 32'h0000_0000, 0, 0, 0,                           0, 1, 32'h0030_0193);
        vecs[5]  = v(0, 32'h0000_0000, 0, 0, 0,                           0, 0, 32'h0030_0193);
        vecs[6]  = v(1, 32'h0000_1000, 0, 0, 0,                           1, 0, 32'h0030_0193);
        vecs[7]  = v(1, 32'h0000_0006, 0, 0, 0,                           1, 1, 32'h0);
        vecs[8]  = v(0, 32'h0000_0000, 0, 0, 0,                           0, 1, 32'h0010_0093);
        vecs[9]  = v(1, 32'h0000_0010, 1, 32'h0000_0010, 32'hDEAD_BEEF,   1, 0, 32'h0010_0093);
        vecs[10] = v(1, 32'h0000_0010, 0, 0, 0,                           1, 1, 32'h0000_0013);
        vecs[11] = v(0, 32'h0000_0000, 1, 32'h0000_1000, 32'h1234_5678,   0, 1, 32'hDEAD_BEEF);
        vecs[12] = v(1, 32'h0000_0000, 0, 0, 0,                           1, 0, 32'hDEAD_BEEF);
        vecs[13] = v(1, 32'hFFFF_FFFC, 0, 0, 0,                           1, 1, 32'h0000_0013);
        vecs[14] = v(0, 32'h0000_0000, 0, 0, 0,                           0, 1, 32'h0);
        vecs[15] = v(0, 32'h0000_0000, 0, 0, 0,                           0, 0, 32'h0);

        // Reset: requests are refused and outputs are cleared.
        req_a = 1'b1;
        req_b = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rst_gnt_a", 32'(gnt_a), 32'd0);
            check("rst_gnt_b", 32'(gnt_b), 32'd0);
            check("rst_rvalid_a", 32'(rv_a), 32'd0);
            check("rst_rdata_b", rd_b, 32'h0);
            cycle_end();
        end
        rst   = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;

        for (int i = 0; i < 5; i++) begin
            we    = 1'b1;
            laddr = 32'(i * 4);
            wdata = pre[i];
            settle();
            cycle_end();
        end
        we = 1'b0;

`ifndef INSTR_MEM_GNT_STALL_EN
        for (int i = 0; i < 16; i++) begin
            req_a  = vecs[i].req;
            addr_a = vecs[i].addr;
            we     = vecs[i].we;
            laddr  = vecs[i].laddr;
            wdata  = vecs[i].wdata;
            settle();
            check($sformatf("vec%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_rvalid", i), 32'(rv_a), 32'(vecs[i].rvalid));
            check($sformatf("vec%0d_rdata", i), rd_a, vecs[i].rdata);
            cycle_end();
        end
        req_a = 1'b0;
        we    = 1'b0;

        // Latency 3 with two outstanding: grants throttle to 1,1,0,0 while the address keeps moving.
        for (int i = 0; i < 12; i++) begin
            req_b  = 1'b1;
            addr_b = 32'((i * 4) % 16);
            settle();
            check($sformatf("thr%0d_gnt_b", i), 32'(gnt_b), 32'((i % 4) < 2));
            cycle_end();
        end
        req_b = 1'b0;
        for (int k = 0; k < 10 && sb_b.size() != 0; k++) begin
            settle();
            cycle_end();
        end
        check("thr_drain_b", 32'(sb_b.size()), 32'd0);
        check("thr_rvalid_eq_gnt_b", 32'(nr_b), 32'(ng_b));

        // Reset with two latency-3 responses in flight.
        req_b  = 1'b1;
        addr_b = 32'h4;
        settle();
        check("inflight0_gnt_b", 32'(gnt_b), 32'd1);
        cycle_end();
        addr_b = 32'h8;
        settle();
        check("inflight1_gnt_b", 32'(gnt_b), 32'd1);
        cycle_end();
        rst   = 1'b1;
        req_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("midrst_gnt_a", 32'(gnt_a), 32'd0);
            check("midrst_gnt_b", 32'(gnt_b), 32'd0);
            check("midrst_rvalid_b", 32'(rv_b), 32'd0);
            check("midrst_rdata_b", rd_b, 32'h0);
            cycle_end();
        end
        rst   = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("postrst_rvalid_b", 32'(rv_b), 32'd0);
            check("postrst_rdata_b", rd_b, 32'h0);
            cycle_end();
        end

        // Counter restarted at zero: two back-to-back grants, answered normally.
        req_b  = 1'b1;
        addr_b = 32'h8;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("postrst_gnt_b", 32'(gnt_b), 32'd1);
            cycle_end();
        end
        req_b = 1'b0;
        got   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (rv_b && !got) begin
                check("postrst_first_rdata_b", rd_b, 32'h0020_0113);
                got = 1'b1;
            end
            cycle_end();
        end
        check("postrst_rvalid_seen_b", 32'(got), 32'd1);
        check("postrst_drain_b", 32'(sb_b.size()), 32'd0);
`else
        // Held request: grant drops exactly when the reference LFSR low bits are zero.
        for (int i = 0; i < 64; i++) begin
            req_a  = 1'b1;
            addr_a = 32'((i % 4) * 4);
            settle();
            check($sformatf("stall%0d_gnt_a", i), 32'(gnt_a), 32'(lfsr_m[1:0] != 2'b00));
            cycle_end();
        end
        req_a = 1'b0;
`endif

        for (int k = 0; k < 10 && (sb_a.size() != 0 || sb_b.size() != 0); k++) begin
            settle();
            cycle_end();
        end
        check("final_drain_a", 32'(sb_a.size()), 32'd0);
        check("final_rvalid_eq_gnt_a", 32'(nr_a), 32'(ng_a));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
